// File: rtl/turbo_deinterleaver.sv
// LTE turbo-code QPP de-interleaver.
// Accepts one interleaved byte per transfer. The QPP address generator is
// stepped 8 times per byte, so each byte's 8 bits are scattered into a
// 6144-bit buffer in a single cycle. Once a whole block (K = 1056 or 6144
// bits) is loaded, the buffer is drained in original bit order, one byte per
// output transfer.
module turbo_deinterleaver (
  input  logic       clk,
  input  logic       reset,
  input  logic       vld_in,
  input  logic       cbs,
  input  logic [7:0] data_in,
  input  logic       rdy_out,
  output logic       rdy_in,
  output logic       vld_out,
  output logic       last_byte,
  output logic [7:0] data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Block sizes and QPP generator constants for the two supported K.
  // g(0) = (f1 + f2) mod K and 2*f2 are precomputed; both are already below K.
  localparam logic [12:0] K_SMALL      = 13'd1056;
  localparam logic [12:0] K_LARGE      = 13'd6144;
  localparam logic [12:0] G0_SMALL     = 13'd83;    // 17 + 66
  localparam logic [12:0] G0_LARGE     = 13'd743;   // 263 + 480
  localparam logic [12:0] TWO_F2_SMALL = 13'd132;   // 2 * 66
  localparam logic [12:0] TWO_F2_LARGE = 13'd960;   // 2 * 480
  localparam logic [9:0]  LAST_SMALL   = 10'd131;   // 1056/8 - 1
  localparam logic [9:0]  LAST_LARGE   = 10'd767;   // 6144/8 - 1

  // Modular add for operands already reduced below k: one conditional subtract.
  function automatic logic [12:0] mod_add(input logic [12:0] a,
                                          input logic [12:0] b,
                                          input logic [12:0] k);
    logic [13:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[12:0];
  endfunction

  // Registered state
  state_t        state_q, state_d;
  logic          big_q, big_d;          // latched cbs for the current block
  logic [12:0]   pi_q, pi_d;            // pi(i) for the next bit to be written
  logic [12:0]   g_q, g_d;              // g(i) matching pi_q
  logic [9:0]    in_cnt_q, in_cnt_d;    // index of next input byte
  logic [9:0]    out_cnt_q, out_cnt_d;  // index of byte on data_out
  logic          rdy_in_q, rdy_in_d;
  logic          vld_out_q, vld_out_d;
  logic          last_q, last_d;
  logic [7:0]    data_q, data_d;
  logic [6143:0] buf_q, buf_d;

  // Per-cycle derived values
  logic          sel_big;
  logic [12:0]   k_cur;
  logic [12:0]   two_f2;
  logic [9:0]    last_idx;
  logic [12:0]   pi_start;
  logic [12:0]   g_start;
  logic [12:0]   wr_addr [8];
  logic [12:0]   pi_step;
  logic [12:0]   g_step;
  logic          in_fire;
  logic          load_data;

  assign rdy_in    = rdy_in_q;
  assign vld_out   = vld_out_q;
  assign last_byte = last_q;
  assign data_out  = data_q;

  assign in_fire = vld_in && rdy_in_q && (state_q != DRAIN);

  // Select block parameters: live cbs on the first byte, latched value after.
  always_comb begin
    sel_big  = (state_q == IDLE) ? cbs : big_q;
    k_cur    = sel_big ? K_LARGE      : K_SMALL;
    two_f2   = sel_big ? TWO_F2_LARGE : TWO_F2_SMALL;
    last_idx = sel_big ? LAST_LARGE   : LAST_SMALL;
    pi_start = (state_q == IDLE) ? 13'd0 : pi_q;
    g_start  = (state_q == IDLE) ? (sel_big ? G0_LARGE : G0_SMALL) : g_q;
  end

  // Unroll 8 generator steps: address for each bit of the byte, plus the
  // generator state to carry into the next byte.
  always_comb begin : gen_addr
    logic [12:0] p;
    logic [12:0] g;
    // NOTE: combinational logic uses blocking '=' so each step sees the
    // previous step's result; sequential blocks use '<=' only.
    p = pi_start;
    g = g_start;
    for (int b = 0; b < 8; b++) begin
      wr_addr[b] = p;
      p = mod_add(p, g, k_cur);
      g = mod_add(g, two_f2, k_cur);
    end
    pi_step = p;
    g_step  = g;
  end

  // Scatter the accepted byte's bits into the next buffer image.
  always_comb begin
    buf_d = buf_q;
    if (in_fire) begin
      for (int b = 0; b < 8; b++) begin
        buf_d[wr_addr[b]] = data_in[b];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    big_d     = big_q;
    pi_d      = pi_q;
    g_d       = g_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    rdy_in_d  = rdy_in_q;
    vld_out_d = vld_out_q;
    last_d    = last_q;
    load_data = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          big_d    = cbs;
          pi_d     = pi_step;
          g_d      = g_step;
          in_cnt_d = 10'd1;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        if (in_fire) begin
          pi_d = pi_step;
          g_d  = g_step;
          if (in_cnt_q == last_idx) begin
            // Byte 0 is read from the next buffer image so the bits written
            // by this final byte are already visible one cycle later.
            state_d   = DRAIN;
            rdy_in_d  = 1'b0;
            vld_out_d = 1'b1;
            last_d    = 1'b0;
            out_cnt_d = 10'd0;
            load_data = 1'b1;
          end else begin
            in_cnt_d = in_cnt_q + 10'd1;
          end
        end
      end

      DRAIN: begin
        if (rdy_out) begin
          if (out_cnt_q == last_idx) begin
            state_d   = IDLE;
            rdy_in_d  = 1'b1;
            vld_out_d = 1'b0;
            last_d    = 1'b0;
            in_cnt_d  = 10'd0;
            out_cnt_d = 10'd0;
            pi_d      = 13'd0;
            g_d       = 13'd0;
          end else begin
            out_cnt_d = out_cnt_q + 10'd1;
            last_d    = ((out_cnt_q + 10'd1) == last_idx);
            load_data = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        rdy_in_d  = 1'b1;
        vld_out_d = 1'b0;
        last_d    = 1'b0;
      end
    endcase

    data_d = load_data ? buf_d[{out_cnt_d, 3'b000} +: 8] : data_q;
  end

  // Control and output registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      big_q     <= 1'b0;
      pi_q      <= 13'd0;
      g_q       <= 13'd0;
      in_cnt_q  <= 10'd0;
      out_cnt_q <= 10'd0;
      rdy_in_q  <= 1'b1;
      vld_out_q <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      big_q     <= big_d;
      pi_q      <= pi_d;
      g_q       <= g_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      rdy_in_q  <= rdy_in_d;
      vld_out_q <= vld_out_d;
      last_q    <= last_d;
      data_q    <= data_d;
    end
  end

  // Bit buffer; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is deliberately not reset; every block rewrites all K
    // bits before they are read, so clearing it would only cost logic.
    if (!reset) buf_q <= buf_d;
  end

endmodule

// File: doc/turbo_deinterleaver.md
TURBO_DEINTERLEAVER -- requirements
Module: turbo_deinterleaver

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 vld_in  input  1  data_in holds a valid interleaved byte.
REQ-004 cbs  input  1  code block size, sampled with the first byte of a block: 0 = K 1056 (132 bytes), 1 = K 6144 (768 bytes).
REQ-005 data_in  input  8  interleaved byte; data_in[b] is stream bit 8n+b of byte n.
REQ-006 rdy_out  input  1  downstream ready; output byte is transferred when vld_out && rdy_out.
REQ-007 rdy_in  output  1  block accepts a byte; input byte is transferred when vld_in && rdy_in.
REQ-008 vld_out  output  1  data_out holds a valid de-interleaved byte.
REQ-009 last_byte  output  1  high with the final output byte of a block.
REQ-010 data_out  output  8  de-interleaved byte; data_out[b] is original bit 8m+b of byte m.

Function
REQ-011 The block SHALL invert the LTE QPP interleaver: for interleaved bit position i, it writes that bit to original position pi(i) = (f1*i + f2*i*i) mod K.
REQ-012 Coefficients SHALL be f1=17, f2=66 for K=1056 and f1=263, f2=480 for K=6144.
REQ-013 pi SHALL be generated incrementally without multipliers: pi(0)=0, g(0)=(f1+f2) mod K, pi(i+1)=(pi(i)+g(i)) mod K, g(i+1)=(g(i)+2*f2) mod K. Every add reduces by one conditional subtract of K; all terms are 13 bits.
REQ-014 Each accepted byte SHALL advance the generator 8 steps in the same cycle, writing bits 0..7 to their 8 addresses.
REQ-015 Storage SHALL be a 6144-bit single buffer. There is no overlap between blocks.
REQ-016 FSM states SHALL be IDLE, LOAD and DRAIN.
REQ-017 IDLE: rdy_in=1 and vld_out=0.
  - On the first transfer, latch cbs, select K/f1/f2, write byte 0 and go to LOAD.
  - If K needs only 1 byte (never), stay in IDLE.
REQ-018 LOAD: rdy_in=1; one byte is written per transfer.
  - Cycles with vld_in=0 stall without any state change.
  - After byte K/8-1 is accepted, go to DRAIN on the next edge.
REQ-019 DRAIN: rdy_in=0.
  - Output bytes 0..K/8-1 in order; vld_out rises on the first cycle of DRAIN.
  - Latency SHALL be exactly 1 cycle from the last input transfer to vld_out=1.
REQ-020 Output handshake:
  - data_out, vld_out and last_byte SHALL hold stable while vld_out && !rdy_out.
  - The byte index advances only on a transfer.
  - With rdy_out held high, one byte is output per cycle.
REQ-021 last_byte SHALL be 1 only while byte K/8-1 is presented.
REQ-022 After the transfer of the last byte, the FSM SHALL return to IDLE; vld_out=0 and rdy_in=1 on the next cycle.
REQ-023 cbs SHALL be ignored outside the first transfer of a block.
REQ-024 vld_in SHALL be ignored in DRAIN.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While reset=1 at a rising edge, the FSM SHALL go to IDLE with the following values after that edge:
  - rdy_in=1
  - vld_out=0
  - last_byte=0
  - data_out=8'h00
  - byte counters and generator cleared.
REQ-027 Reset SHALL take priority over any concurrent handshake. A reset in LOAD or DRAIN abandons the block, and the next accepted byte starts a new block.
REQ-028 Buffer contents SHALL NOT be reset; every block fully overwrites all K bits before DRAIN.

Verification
REQ-029 K=1056 golden vector: feed the 132-byte interleaved stream whose byte 0 is 8'h65 with rdy_out=1. Require byte 0 out = 8'hA3, last_byte only on byte 131, and vld_out exactly 1 cycle after input byte 131.
REQ-030 K=1056 single bit: the stream is all-zero except bit i=1 (byte 0 = 8'h02). Require output byte 10 = 8'h08 and all other bytes 8'h00. Repeat with i=2 (8'h04): require byte 37 = 8'h04.
REQ-031 K=6144 single bit: bit i=1 set, cbs=1. Require output byte 92 = 8'h80, all others zero, 768 output bytes, and last_byte on byte 767.
REQ-032 Backpressure: in DRAIN, drop rdy_out for 2 cycles at byte 5. Require data_out and vld_out held, and no byte skipped or duplicated.
REQ-033 Input stalls: deassert vld_in for 3 cycles mid-LOAD, and toggle cbs during LOAD. Require output identical to the no-stall run.
REQ-034 Reset mid-DRAIN at byte 40: require vld_out=0 and rdy_in=1 after the edge. A following full K=1056 block SHALL produce correct output.
